adder_sched: RTL



---
 rtl/adder_sched.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/adder_sched.sv
// -----------------------------------------------------------------------------
// adder_sched
//
// Purpose:
//   Shares a single 8-bit adder slice between NREQ requesters. A round-robin
//   arbiter picks one requester, its operands are captured, and the WIDTH-bit
//   addition is then carried out byte-serially through the slice, least
//   significant byte first, with the carry chained from beat to beat. The
//   finished sum and carry-out are registered and presented to the display
//   side together with a one-cycle completion pulse addressed to the owner.
//
//   Operation timeline for a grant captured on edge E0 (BEATS = WIDTH/8):
//     E0            : capture operands, pointer update, gnt raised
//     E0+1..E0+BEATS: one byte per edge; the last one loads sum/cout, raises done
//     E0+BEATS+1    : back to IDLE
//     E0+BEATS+2    : earliest next capture
//
// Ports:
//   clk   in   1           rising-edge system clock
//   rst   in   1           synchronous reset, active-high
//   req   in   NREQ        level request, bit i belongs to requester i
//   a     in   NREQ*WIDTH  operand A, requester i at a[i*WIDTH +: WIDTH]
//   b     in   NREQ*WIDTH  operand B, same packing as a
//   gnt   out  NREQ        one-hot pulse in the cycle after operand capture
//   done  out  NREQ        one-hot pulse to the owner when sum/cout are valid
//   sum   out  WIDTH       sum of the last completed operation
//   cout  out  1           carry-out of the last completed operation
//   busy  out  1           high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module adder_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a,
  input  logic [NREQ*WIDTH-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int BEATS = WIDTH / 8;
  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Pointer reset value makes requester 0 the first one searched.
  localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NREQ - 1);
  localparam logic [BW-1:0]   BEAT_LAST = BW'(BEATS - 1);
  localparam logic [NREQ-1:0] ONEHOT0   = NREQ'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [IDXW-1:0]   r_last;
  logic [IDXW-1:0]   r_owner;
  logic [BW-1:0]     r_beat;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;

  // ---------------------------------------------------------------------------
  // Combinational wires
  // ---------------------------------------------------------------------------
  state_t            w_state_next;
  logic              w_take;
  logic              w_step;
  logic              w_finish;
  logic              w_found;
  logic [IDXW-1:0]   w_winner;
  int                w_pos;
  logic [WIDTH-1:0]  w_a_win;
  logic [WIDTH-1:0]  w_b_win;
  logic [7:0]        w_a_byte;
  logic [7:0]        w_b_byte;
  logic [8:0]        w_byte_sum;
  logic [WIDTH-1:0]  w_acc_next;
  logic [NREQ-1:0]   w_win_onehot;
  logic [NREQ-1:0]   w_owner_onehot;

  // Round-robin search: first set request starting just after the last winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_pos    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos    = int'(r_last) + k;
      w_pos    = (w_pos >= NREQ) ? (w_pos - NREQ) : w_pos;
      // Only the first hit in search order may claim the grant.
      w_winner = (req[IDXW'(w_pos)] && !w_found) ? IDXW'(w_pos) : w_winner;
      w_found  = w_found | req[IDXW'(w_pos)];
    end
  end

  // Operand multiplexers selecting the winner's slice of the packed buses.
  always_comb begin
    w_a_win = '0;
    w_b_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_a_win = w_a_win | ((w_winner == IDXW'(i)) ? a[i*WIDTH +: WIDTH] : '0);
      w_b_win = w_b_win | ((w_winner == IDXW'(i)) ? b[i*WIDTH +: WIDTH] : '0);
    end
  end

  // Byte slice adder: picks the current byte, adds with the chained carry and
  // merges the result byte back into the accumulator image.
  always_comb begin
    w_a_byte = 8'h00;
    w_b_byte = 8'h00;
    for (int j = 0; j < BEATS; j++) begin
      w_a_byte = w_a_byte | ((r_beat == BW'(j)) ? r_a[j*8 +: 8] : 8'h00);
      w_b_byte = w_b_byte | ((r_beat == BW'(j)) ? r_b[j*8 +: 8] : 8'h00);
    end
    w_byte_sum = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'h00, r_carry};
    w_acc_next = r_acc;
    for (int j = 0; j < BEATS; j++) begin
      w_acc_next[j*8 +: 8] = (r_beat == BW'(j)) ? w_byte_sum[7:0] : r_acc[j*8 +: 8];
    end
  end

  // One-hot encodings for the grant and completion pulses.
  always_comb begin
    w_win_onehot   = ONEHOT0 << w_winner;
    w_owner_onehot = ONEHOT0 << r_owner;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_take       = 1'b1;
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (r_beat == BEAT_LAST) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      // No arbitration here: a request pending now is served from IDLE.
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath, arbitration pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= LAST_RST;
      r_owner <= '0;
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-raised below.
      r_gnt  <= '0;
      r_done <= '0;
      r_busy <= (w_state_next != ST_IDLE);
      if (w_take) begin
        r_a     <= w_a_win;
        r_b     <= w_b_win;
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_beat  <= '0;
        r_carry <= 1'b0;
        r_acc   <= '0;
        r_gnt   <= w_win_onehot;
      end
      if (w_step) begin
        r_acc   <= w_acc_next;
        r_carry <= w_byte_sum[8];
        r_beat  <= r_beat + BW'(1);
      end
      // sum/cout are only touched here so they hold across idle and CALC.
      if (w_finish) begin
        r_sum  <= w_acc_next;
        r_cout <= w_byte_sum[8];
        r_done <= w_owner_onehot;
      end
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;

endmodule
